mem_seq_ctrl: RTL
=================

# mem_seq_ctrl

Parametrised memory exercise sequencer for the on-board memory demos. It writes a selectable data pattern into a synchronous single-port RAM, one word per programmable tick, across DEPTH consecutive addresses. It then reads every word back and compares it against the expected pattern, reporting a sticky error flag and a mismatch count. It sits between the board-level start/mode inputs and the RAM wrapper, and replaces the fixed 1 s, single-address write controller.

## Interface
- AW, 4, address width
- DW, 4, data width
- DEPTH, 16, number of words exercised; 1 ≤ DEPTH ≤ 2^AW
- TICK, 49_999_999, wait length in cycles minus one (1 s at 50 MHz); simulation uses small values
- TW, 26, tick counter width; must hold TICK
---
- sysclk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- mode  in  2  pattern select; latched on accepted start
- rd_data  in  DW  RAM read data, valid one cycle after re
- we  out  1  RAM write strobe, one cycle per word
- re  out  1  RAM read strobe, one cycle per word
- addr  out  AW  RAM address
- wdata  out  DW  RAM write data
- busy  out  1  high from accepted start until done or abort
- done  out  1  one-cycle pulse when the check pass completes
- err  out  1  sticky mismatch flag, cleared on accepted start
- err_cnt  out  AW+1  number of mismatching words in the last run

## Operation
- Pattern p(a) for address a, truncated to DW bits:
  - mode 0: a+1
  - mode 1: 1 << (a mod DW), a walking one
  - mode 2: ~a
  - mode 3: all ones
- States: IDLE, WAIT_W, WRITE, WAIT_R, READ, CHECK, DONE.
- IDLE: start=1 → WAIT_W. On this transition: addr=0, mode latched, err=0, err_cnt=0, busy=1.
- WAIT_W: the tick counter runs 0..TICK, with addr and wdata=p(addr) stable. At count==TICK → WRITE.
- WRITE: we=1 for exactly one cycle.
  - If addr==DEPTH-1 → WAIT_R with addr=0.
  - Otherwise addr+1 → WAIT_W.
- WAIT_R: the counter runs 0..TICK. At count==TICK → READ.
- READ: re=1 for exactly one cycle → CHECK.
- CHECK: compare rd_data with p(addr).
  - On mismatch: err=1 and err_cnt+1. err_cnt cannot overflow because DEPTH ≤ 2^AW.
  - If addr==DEPTH-1 → DONE.
  - Otherwise addr+1 → WAIT_R.
- DONE: done=1 for one cycle, busy=0 → IDLE. addr returns to 0 and wdata to 0. err and err_cnt are held.
- The tick counter is cleared on every entry to WAIT_W or WAIT_R and held at 0 outside those states.
- start while busy is ignored.
- mode changes while busy are ignored; the latched value is used.
- abort (any state other than IDLE) → IDLE next cycle:
  - we, re, busy and done go to 0; addr and wdata go to 0.
  - done is not pulsed; err and err_cnt are held.
- abort has priority over start in the same cycle.
- start and abort asserted together while in IDLE: remain in IDLE.

## Timing
- Reset values: state IDLE; we=0, re=0, addr=0, wdata=0, busy=0, done=0, err=0, err_cnt=0; counter=0.
- All outputs are registered.
- start accepted at edge n → busy=1 at n+1 → first we=1 at n+1+(TICK+1).
- Write period: TICK+2 cycles per word.
- Read period: TICK+3 cycles per word (wait, READ, CHECK).
- Run length: DEPTH·(2·TICK+5) + 1 cycles from busy rising to the done pulse.
- addr and wdata are stable for the whole WAIT_W and the WRITE cycle. They never change in the same cycle as we=1.
- rd_data is sampled in CHECK, exactly one cycle after re=1. The RAM read latency is fixed at 1.
- err rises in the cycle after the mismatching CHECK.

## Test plan
- TICK=3, DEPTH=16, mode 0, ideal RAM model:
  - 16 writes of 1,2,…,15,0 to addr 0..15, each spaced 5 cycles.
  - 16 reads, each spaced 6 cycles.
  - done pulses once at cycle 16·11+1 after busy rose; err=0, err_cnt=0.
- Mode 1, DW=4: wdata sequence 1,2,4,8,1,… and the check passes.
- Mode 2: wdata = F,E,…,0. Same run with the RAM model forcing bit 0 stuck at 0 on reads: err=1, err_cnt=8.
- Abort asserted during the WRITE of addr 5:
  - next cycle: IDLE, we=0, busy=0, no done pulse.
  - A new start then restarts at addr 0 with err cleared.
- start pulsed while busy, and mode toggled mid-run: both ignored, and the sequence matches the latched mode.
- rst_n asserted mid read phase: all outputs return to their reset values immediately. After release, the block stays in IDLE until start.

Source files
------------

// File: rtl/mem_seq_ctrl_if.sv
// Control and RAM-side signals of the memory exercise sequencer.
// master is the sequencer's view; slave is the board/RAM side.
interface mem_seq_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [DW-1:0] rd_data;
  logic          we;
  logic          re;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   err_cnt;

  modport master (
    input  start, abort, mode, rd_data,
    output we, re, addr, wdata, busy, done, err, err_cnt
  );

  modport slave (
    output start, abort, mode, rd_data,
    input  we, re, addr, wdata, busy, done, err, err_cnt
  );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Writes a mode-selected pattern over DEPTH words (one word per tick), then reads
// every word back and counts mismatches into a sticky err flag and err_cnt.
module mem_seq_ctrl #(
  parameter int AW    = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 16,
  parameter int TICK  = 49_999_999,
  parameter int TW    = 26
) (
  input  logic           sysclk,
  input  logic           rst_n,
  mem_seq_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, WAIT_W, WRITE, WAIT_R, READ, CHECK, DONE} stateT;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(TICK);

  stateT         state;
  logic [TW-1:0] tickCnt;
  logic [1:0]    modeLat;
  logic          tickHit;
  logic          lastAddr;

  function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [AW-1:0] a);
    logic [DW-1:0] p;
    case (m)
      2'd0:    p = DW'(a) + DW'(1);
      2'd1:    p = DW'(1) << (int'(a) % DW);
      2'd2:    p = DW'(~a);
      default: p = '1;
    endcase
    return p;
  endfunction

  assign tickHit  = (tickCnt == TICK_END);
  assign lastAddr = (bus.addr == LAST_ADDR);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tickCnt     <= '0;
      modeLat     <= '0;
      bus.we      <= 1'b0;
      bus.re      <= 1'b0;
      bus.addr    <= '0;
      bus.wdata   <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      bus.we   <= 1'b0;
      bus.re   <= 1'b0;
      bus.done <= 1'b0;
      // Abort wins over everything, including a start in the same cycle.
      if (bus.abort && state != IDLE) begin
        state     <= IDLE;
        tickCnt   <= '0;
        bus.addr  <= '0;
        bus.wdata <= '0;
        bus.busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state       <= WAIT_W;
              tickCnt     <= '0;
              modeLat     <= bus.mode;
              bus.addr    <= '0;
              bus.wdata   <= pattern(bus.mode, '0);
              bus.err     <= 1'b0;
              bus.err_cnt <= '0;
              bus.busy    <= 1'b1;
            end
          end
          WAIT_W: begin
            if (tickHit) begin
              state   <= WRITE;
              tickCnt <= '0;
              bus.we  <= 1'b1;
            end else begin
              tickCnt <= tickCnt + TW'(1);
            end
          end
          WRITE: begin
            if (lastAddr) begin
              state     <= WAIT_R;
              bus.addr  <= '0;
              bus.wdata <= '0;
            end else begin
              state     <= WAIT_W;
              bus.addr  <= bus.addr + AW'(1);
              bus.wdata <= pattern(modeLat, bus.addr + AW'(1));
            end
          end
          WAIT_R: begin
            if (tickHit) begin
              state   <= READ;
              tickCnt <= '0;
              bus.re  <= 1'b1;
            end else begin
              tickCnt <= tickCnt + TW'(1);
            end
          end
          READ: state <= CHECK;
          CHECK: begin
            // RAM read latency is one cycle, so rd_data belongs to the READ just issued.
            if (bus.rd_data != pattern(modeLat, bus.addr)) begin
              bus.err     <= 1'b1;
              bus.err_cnt <= bus.err_cnt + (AW+1)'(1);
            end
            if (lastAddr) begin
              state <= DONE;
            end else begin
              state    <= WAIT_R;
              bus.addr <= bus.addr + AW'(1);
            end
          end
          DONE: begin
            state     <= IDLE;
            bus.done  <= 1'b1;
            bus.busy  <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  a_we_re_excl: assert property (@(posedge sysclk) disable iff (!rst_n) !(bus.we && bus.re));
  a_done_idle:  assert property (@(posedge sysclk) disable iff (!rst_n) bus.done |-> !bus.busy);
endmodule
